cluster_eval_sched: RTL and testbench

CLUSTER_EVAL_SCHED -- requirements
Module: cluster_eval_sched

---
 rtl/cluster_eval_pkg.sv | 25 ++
 rtl/cluster_eval_sched_if.sv | 40 ++++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/cluster_eval_sched.sv | 134 +++++++++++++
 tb/tb_cluster_eval_sched.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cluster_eval_pkg.sv
// -----------------------------------------------------------------------------
// cluster_eval_pkg
// Shared constants and types for the cluster evaluator scheduler.
//   DEF_NREQ   : default number of requesters sharing one evaluator
//   DEF_IW     : default evaluator input-vector width
//   DEF_OW     : default evaluator output width
//   DEF_SETTLE : default evaluator settle time in cycles
//   CNT_W      : width of the settle down-counter (covers SETTLE up to 15)
//   state_e    : scheduler FSM state encoding
// -----------------------------------------------------------------------------
package cluster_eval_pkg;

   localparam int DEF_NREQ   = 4;
   localparam int DEF_IW     = 1894;
   localparam int DEF_OW     = 1;
   localparam int DEF_SETTLE = 2;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

endpackage

// File: rtl/cluster_eval_sched_if.sv
// -----------------------------------------------------------------------------
// cluster_eval_sched_if
// Request/response bundle between the requesters and the scheduler.
//   req_valid [NREQ]     : per-requester request
//   req_data  [NREQ*IW]  : per-requester input vector, requester k at [k*IW +: IW]
//   req_ready [NREQ]     : one-hot grant/accept
//   rsp_valid            : response valid
//   rsp_id    [clog2]    : requester index of the response
//   rsp_data  [OW]       : captured evaluator result
//   rsp_ready            : response consumer ready
// master = requester/consumer side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface cluster_eval_sched_if
   import cluster_eval_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IW   = DEF_IW,
   parameter int OW   = DEF_OW
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]    req_valid;
   logic [NREQ*IW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               rsp_valid;
   logic [IDW-1:0]     rsp_id;
   logic [OW-1:0]      rsp_data;
   logic               rsp_ready;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data
   );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request found when
// scanning upward from ptr, wrapping at N.
//   req   [N]   : request vector
//   ptr   [IDW] : index where the search starts (must be < N)
//   grant [N]   : one-hot winner, zero when no request
//   idx   [IDW] : encoded winner index, zero when no request
//   any         : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] idx,
   output logic           any
);

   logic [IDW:0]   sum;
   logic [IDW-1:0] pos;

   // NOTE: every signal written in this block gets a default first, so no
   // path through the loop leaves one unassigned and no latch is inferred.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      sum   = '0;
      pos   = '0;
      for (int i = 0; i < N; i++) begin
         // ptr + i never exceeds 2N-2, so a single conditional subtract
         // implements the wrap for any N, not only powers of two.
         sum = {1'b0, ptr} + (IDW+1)'(i);
         if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
         pos = sum[IDW-1:0];
         if (!any && req[pos]) begin
            any        = 1'b1;
            grant[pos] = 1'b1;
            idx        = pos;
         end
      end
   end

endmodule

// File: rtl/cluster_eval_sched.sv
// -----------------------------------------------------------------------------
// cluster_eval_sched
// Time-shares one external combinational evaluator among NREQ requesters.
// A round-robin winner is accepted in IDLE, its vector is registered onto
// eval_in, the evaluator is given SETTLE cycles, and the result is offered
// as a response held until the consumer takes it.
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   bus (slave)       : request/response bundle, see cluster_eval_sched_if
//   eval_in  [IW]     : registered drive to the evaluator, stable between accepts
//   eval_out [OW]     : evaluator result
//   busy              : high in every state except IDLE
//   done_cnt [16]     : completed-response count, wraps 0xFFFF -> 0
// -----------------------------------------------------------------------------
module cluster_eval_sched
   import cluster_eval_pkg::*;
#(
   parameter int NREQ   = DEF_NREQ,
   parameter int IW     = DEF_IW,
   parameter int OW     = DEF_OW,
   parameter int SETTLE = DEF_SETTLE
) (
   input  logic                  clk,
   input  logic                  rst_n,
   cluster_eval_sched_if.slave   bus,
   output logic [IW-1:0]         eval_in,
   input  logic [OW-1:0]         eval_out,
   output logic                  busy,
   output logic [15:0]           done_cnt
);

   localparam int IDW = $clog2(NREQ);

   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_SETTLE = ST_SETTLE;
   localparam logic [1:0] S_RESP   = ST_RESP;

   if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("cluster_eval_sched: SETTLE must be within 1..15");
   end
   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("cluster_eval_sched: NREQ must be within 2..8");
   end

   logic [1:0]       state;
   logic [IDW-1:0]   ptr;
   logic [CNT_W-1:0] cnt;
   logic [IW-1:0]    eval_in_q;
   logic             rsp_valid_q;
   logic [IDW-1:0]   rsp_id_q;
   logic [OW-1:0]    rsp_data_q;
   logic [15:0]      done_cnt_q;

   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   win_idx;
   logic             win_any;
   logic [IW-1:0]    sel_data;
   logic [IDW-1:0]   next_ptr;
   logic             accept;

   rr_arbiter #(.N(NREQ), .IDW(IDW)) u_arb (
      .req   (bus.req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (win_idx),
      .any   (win_any)
   );

   // Grants are only offered while idle, so a request can be consumed at
   // most once per transaction and never alongside a response handshake.
   assign accept        = (state == S_IDLE) && win_any;
   assign bus.req_ready = (state == S_IDLE) ? grant : '0;
   assign next_ptr      = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (grant[k]) sel_data = bus.req_data[k*IW +: IW];
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   // The wide eval_in register is reset too, so the evaluator sees a defined
   // all-zero vector rather than power-up garbage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         ptr         <= '0;
         cnt         <= '0;
         eval_in_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         done_cnt_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  eval_in_q <= sel_data;
                  rsp_id_q  <= win_idx;
                  cnt       <= CNT_W'(SETTLE - 1);
                  ptr       <= next_ptr;
                  state     <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt == '0) begin
                  rsp_data_q  <= eval_out;
                  rsp_valid_q <= 1'b1;
                  state       <= S_RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  done_cnt_q  <= done_cnt_q + 16'd1;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign eval_in       = eval_in_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign busy          = (state != S_IDLE);
   assign done_cnt      = done_cnt_q;

endmodule

// File: tb/tb_cluster_eval_sched.sv
// -----------------------------------------------------------------------------
// tb_cluster_eval_sched
// Self-checking bench for cluster_eval_sched. The external evaluator is
// modelled as the parity of eval_in. A transaction-level reference tracks
// the round-robin pointer, the cycle a pending response is due, and the
// completed count; every cycle the DUT outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_cluster_eval_sched;
   import cluster_eval_pkg::*;

   localparam int NREQ   = 4;
   localparam int IW     = 1894;
   localparam int OW     = 1;
   localparam int SETTLE = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [IW-1:0]     eval_in;
   logic [OW-1:0]     eval_out;
   logic              busy;
   logic [15:0]       done_cnt;

   cluster_eval_sched_if #(.NREQ(NREQ), .IW(IW), .OW(OW)) bus ();

   cluster_eval_sched #(.NREQ(NREQ), .IW(IW), .OW(OW), .SETTLE(SETTLE)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .eval_in  (eval_in),
      .eval_out (eval_out),
      .busy     (busy),
      .done_cnt (done_cnt)
   );

   always #5 clk = ~clk;

   assign eval_out = ^eval_in;

   int total = 0;
   int bad   = 0;

   // reference model
   bit            m_idle;
   int            m_ptr;
   int            m_rsp_due;
   int            m_id;
   logic [IW-1:0] m_eval;
   logic [OW-1:0] m_data;
   int            m_done;
   int            cyc = 0;

   // last sampled DUT outputs
   logic [NREQ-1:0] last_ready;
   logic            last_rsp_valid;
   int              last_rsp_id;
   logic [OW-1:0]   last_rsp_data;
   logic            last_busy;
   logic [15:0]     last_done;

   typedef struct {
      logic [NREQ-1:0] rv;
      int              exp_id;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] rv, input int ptr);
      for (int i = 0; i < NREQ; i++) begin
         if (rv[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
      end
      return -1;
   endfunction

   function automatic int onehot_idx(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic rand_data();
      logic [NREQ*IW+31:0] tmp;
      tmp = '0;
      for (int k = 0; k < NREQ*IW; k += 32) tmp[k +: 32] = $urandom();
      bus.req_data = tmp[NREQ*IW-1:0];
   endtask

   task automatic model_reset();
      m_idle    = 1'b1;
      m_ptr     = 0;
      m_rsp_due = 0;
      m_id      = 0;
      m_eval    = '0;
      m_data    = '0;
      m_done    = 0;
   endtask

   // One clock cycle: compare at the falling edge, advance the model for
   // the coming rising edge, return 1 time unit after that edge.
   task automatic tick();
      logic [NREQ-1:0] exp_ready;
      logic            exp_rsp;
      int              w;
      @(negedge clk);
      cyc++;
      exp_ready = '0;
      w = -1;
      if (m_idle) begin
         w = rr_pick(bus.req_valid, m_ptr);
         if (w >= 0) exp_ready = NREQ'(1) << w;
      end
      exp_rsp = !m_idle && (cyc >= m_rsp_due);
      last_ready     = bus.req_ready;
      last_rsp_valid = bus.rsp_valid;
      last_rsp_id    = int'(bus.rsp_id);
      last_rsp_data  = bus.rsp_data;
      last_busy      = busy;
      last_done      = done_cnt;
      check("req_ready", bus.req_ready, exp_ready);
      check("busy", busy, !m_idle);
      check("rsp_valid", bus.rsp_valid, exp_rsp);
      check("done_cnt", done_cnt, m_done);
      check("rsp_id", bus.rsp_id, m_id);
      if (exp_rsp) check("rsp_data", bus.rsp_data, m_data);
      check("eval_in_match", eval_in === m_eval, 1'b1);
      if (w >= 0) begin
         m_ptr     = (w + 1) % NREQ;
         m_idle    = 1'b0;
         m_rsp_due = cyc + SETTLE + 1;
         m_id      = w;
         m_eval    = bus.req_data[w*IW +: IW];
         m_data    = ^m_eval;
      end else if (exp_rsp && bus.rsp_ready) begin
         m_idle = 1'b1;
         m_done = (m_done + 1) % 65536;
      end
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset asserted mid-cycle; all outputs must clear at once.
   task automatic do_reset();
      bus.req_valid = '0;
      rst_n = 1'b0;
      #1;
      check("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done_cnt", done_cnt, 16'd0);
      check("rst_rsp_id", bus.rsp_id, 0);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_eval_in_zero", eval_in === '0, 1'b1);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Full transaction with rsp_ready held high; checks grant, id, latency.
   task automatic run_txn(input logic [NREQ-1:0] rv, input int exp_id, input string tag);
      int t0;
      bit got;
      bus.req_valid = rv;
      bus.rsp_ready = 1'b1;
      got = 1'b0;
      t0  = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (last_ready != '0) begin
            got = 1'b1;
            t0  = cyc;
         end
      end
      check({tag, "_accept_seen"}, got, 1'b1);
      check({tag, "_grant"}, last_ready, NREQ'(1) << exp_id);
      bus.req_valid = '0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (last_rsp_valid) got = 1'b1;
      end
      check({tag, "_rsp_seen"}, got, 1'b1);
      check({tag, "_latency"}, cyc - t0, SETTLE + 1);
      check({tag, "_rsp_id"}, last_rsp_id, exp_id);
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int order [5];
      int acc_at [5];
      int exp_order [5];
      bit got;

      tbl[0] = '{4'b0001, 0};
      tbl[1] = '{4'b0001, 0};
      tbl[2] = '{4'b1111, 1};
      tbl[3] = '{4'b1011, 3};
      tbl[4] = '{4'b0110, 1};
      tbl[5] = '{4'b0011, 0};
      tbl[6] = '{4'b1000, 3};
      tbl[7] = '{4'b1100, 2};
      exp_order = '{0, 1, 2, 3, 0};

      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.rsp_ready = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_reset();

      // single request, evaluator result 1
      bus.req_data    = '0;
      bus.req_data[0] = 1'b1;
      run_txn(4'b0001, 0, "single");
      check("single_rsp_data", last_rsp_data, 1'b1);
      check("single_done", last_done, 16'd1);

      // round-robin vectors from a fresh pointer
      do_reset();
      for (int v = 0; v < 8; v++) begin
         rand_data();
         run_txn(tbl[v].rv, tbl[v].exp_id, $sformatf("tbl%0d", v));
      end

      // all four requesting continuously
      do_reset();
      bus.req_valid = '1;
      bus.rsp_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 40 && n < 5; i++) begin
         rand_data();
         tick();
         if (last_ready != '0) begin
            order[n]  = onehot_idx(last_ready);
            acc_at[n] = cyc;
            n++;
            if (n == 5) bus.req_valid = '0;
         end
      end
      check("cont_accepts", n, 5);
      for (int i = 0; i < 5; i++) check($sformatf("cont_order%0d", i), order[i], exp_order[i]);
      for (int i = 1; i < 5; i++) check($sformatf("cont_spacing%0d", i), acc_at[i] - acc_at[i-1], SETTLE + 2);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (last_rsp_valid) got = 1'b1;
      end
      tick();
      check("cont_done_cnt", last_done, 16'd5);

      // backpressure in RESP
      rand_data();
      bus.req_valid = 4'b0100;
      bus.rsp_ready = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (last_ready != '0) got = 1'b1;
      end
      check("bp_accept_seen", got, 1'b1);
      bus.req_valid = '1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (last_rsp_valid) got = 1'b1;
      end
      check("bp_rsp_seen", got, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_req_ready", last_ready, 4'b0000);
         check("bp_busy", last_busy, 1'b1);
         check("bp_rsp_valid", last_rsp_valid, 1'b1);
         check("bp_rsp_id", last_rsp_id, 2);
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      tick();
      tick();
      check("bp_idle_after", last_busy, 1'b0);
      check("bp_done_cnt", last_done, 16'd6);

      // reset during SETTLE discards the transaction and restarts ptr at 0
      rand_data();
      bus.req_valid = 4'b0010;
      tick();
      bus.req_valid = '0;
      tick();
      do_reset();
      rand_data();
      run_txn(4'b1010, 1, "post_rst");
      check("post_rst_done", last_done, 16'd1);

      // done_cnt wrap
      force dut.done_cnt_q = 16'hFFFF;
      #1;
      release dut.done_cnt_q;
      m_done = 16'hFFFF;
      rand_data();
      run_txn(4'b0100, 2, "wrap");
      check("wrap_done_cnt", last_done, 16'h0000);

      // randomized traffic against the reference model
      for (int i = 0; i < 2000; i++) begin
         bus.req_valid = NREQ'($urandom());
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         rand_data();
         tick();
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      repeat (6) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
